// File: rtl/hvac_pkg.sv
// Shared codes for the HVAC source controller: output encodings, FSM states
// and the sensor/threshold snapshot captured on each accepted sample.
package hvac_pkg;

    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_SOLAR   = 2'd1,
        SRC_AMBIENT = 2'd2,
        SRC_GEO     = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_HEAT = 2'd1,
        MODE_COOL = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DEAD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] solar_level;
        logic [15:0] solar_th;
        logic [7:0]  room_temp;
        logic [7:0]  ambient_temp;
        logic [7:0]  solar_cool_th;
        logic [7:0]  solar_heat_th;
        logic [7:0]  ambient_cool_th;
        logic [7:0]  ambient_heat_th;
        logic [7:0]  geo_cool_th;
        logic [7:0]  geo_heat_th;
    } snap_t;

    // Counter width that can hold the value n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/source_arbiter.sv
// Combinational source/mode request: first eligible source in priority order
// solar, ambient, geothermal, with cooling tested before heating.
module source_arbiter
    import hvac_pkg::*;
(
    input  snap_t snap_i,
    output src_e  req_src_o,
    output mode_e req_mode_o
);

    logic signed [7:0] room;
    logic signed [7:0] amb;
    logic              solar_ok;

    assign room     = $signed(snap_i.room_temp);
    assign amb      = $signed(snap_i.ambient_temp);
    assign solar_ok = snap_i.solar_level >= snap_i.solar_th;

    always_comb begin
        req_src_o  = SRC_NONE;
        req_mode_o = MODE_OFF;
        if (solar_ok && (room > $signed(snap_i.solar_cool_th))) begin
            req_src_o  = SRC_SOLAR;
            req_mode_o = MODE_COOL;
        end else if (solar_ok && (room < $signed(snap_i.solar_heat_th))) begin
            req_src_o  = SRC_SOLAR;
            req_mode_o = MODE_HEAT;
        // Outside air only helps when it sits on the useful side of the room.
        end else if ((amb < room) && (room > $signed(snap_i.ambient_cool_th))) begin
            req_src_o  = SRC_AMBIENT;
            req_mode_o = MODE_COOL;
        end else if ((amb > room) && (room < $signed(snap_i.ambient_heat_th))) begin
            req_src_o  = SRC_AMBIENT;
            req_mode_o = MODE_HEAT;
        end else if (room > $signed(snap_i.geo_cool_th)) begin
            req_src_o  = SRC_GEO;
            req_mode_o = MODE_COOL;
        end else if (room < $signed(snap_i.geo_heat_th)) begin
            req_src_o  = SRC_GEO;
            req_mode_o = MODE_HEAT;
        end
    end

endmodule

// File: rtl/hvac_source_controller.sv
// HVAC source sequencer: snapshots a sample, arbitrates a source/mode, and
// switches through an all-off dead time once the minimum run dwell is met.
//
// state | meaning
// IDLE  | outputs off, waiting for a sample
// EVAL  | request computed from the snapshot, switch decision made
// DEAD  | all outputs forced off for DEAD_CYCLES cycles before a change
// RUN   | a source is driving the pump, waiting for the next sample
module hvac_source_controller
    import hvac_pkg::*;
#(
    parameter int DEAD_CYCLES     = 16,
    parameter int MIN_RUN_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] solar_level,
    input  logic [7:0]  room_temp,
    input  logic [7:0]  ambient_temp,
    input  logic [15:0] solar_th,
    input  logic [7:0]  solar_cooldown_th,
    input  logic [7:0]  solar_heatup_th,
    input  logic [7:0]  ambient_cooldown_th,
    input  logic [7:0]  ambient_heatup_th,
    input  logic [7:0]  geothermal_cooldown_th,
    input  logic [7:0]  geothermal_heatup_th,
    output logic [1:0]  src_sel,
    output logic [1:0]  hvac_mode,
    output logic        pump_en,
    output logic        change
);

    localparam int DW = cnt_width(DEAD_CYCLES);
    localparam int RW = cnt_width(MIN_RUN_SAMPLES);

    state_e          state_q, state_d;
    snap_t           snap_q, snap_d;
    src_e            src_q, src_d, pend_src_q, pend_src_d, req_src;
    mode_e           mode_q, mode_d, pend_mode_q, pend_mode_d, req_mode;
    logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic            change_q, change_d;
    logic            same_req;
    logic            dwell_met;

    source_arbiter u_arb (
        .snap_i     (snap_q),
        .req_src_o  (req_src),
        .req_mode_o (req_mode)
    );

    assign same_req  = (req_src == src_q) && (req_mode == mode_q);
    assign dwell_met = run_cnt_q >= RW'(MIN_RUN_SAMPLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            src_q       <= SRC_NONE;
            mode_q      <= MODE_OFF;
            pend_src_q  <= SRC_NONE;
            pend_mode_q <= MODE_OFF;
            dead_cnt_q  <= '0;
            run_cnt_q   <= '0;
            change_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            src_q       <= src_d;
            mode_q      <= mode_d;
            pend_src_q  <= pend_src_d;
            pend_mode_q <= pend_mode_d;
            dead_cnt_q  <= dead_cnt_d;
            run_cnt_q   <= run_cnt_d;
            change_q    <= change_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        src_d       = src_q;
        mode_d      = mode_q;
        pend_src_d  = pend_src_q;
        pend_mode_d = pend_mode_q;
        dead_cnt_d  = dead_cnt_q;
        run_cnt_d   = run_cnt_q;
        change_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (sample_valid) begin
                    snap_d.solar_level     = solar_level;
                    snap_d.solar_th        = solar_th;
                    snap_d.room_temp       = room_temp;
                    snap_d.ambient_temp    = ambient_temp;
                    snap_d.solar_cool_th   = solar_cooldown_th;
                    snap_d.solar_heat_th   = solar_heatup_th;
                    snap_d.ambient_cool_th = ambient_cooldown_th;
                    snap_d.ambient_heat_th = ambient_heatup_th;
                    snap_d.geo_cool_th     = geothermal_cooldown_th;
                    snap_d.geo_heat_th     = geothermal_heatup_th;
                    state_d                = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Mode is off exactly when the prior state was IDLE.
                if (same_req) begin
                    state_d = (mode_q == MODE_OFF) ? ST_IDLE : ST_RUN;
                    if ((mode_q != MODE_OFF) && !dwell_met) run_cnt_d = run_cnt_q + RW'(1);
                end else if ((mode_q == MODE_OFF) || dwell_met) begin
                    state_d     = ST_DEAD;
                    dead_cnt_d  = DW'(DEAD_CYCLES);
                    pend_src_d  = req_src;
                    pend_mode_d = req_mode;
                    src_d       = SRC_NONE;
                    mode_d      = MODE_OFF;
                end else begin
                    state_d   = ST_RUN;
                    run_cnt_d = run_cnt_q + RW'(1);
                end
            end
            ST_DEAD: begin
                if (dead_cnt_q <= DW'(1)) begin
                    state_d    = (pend_mode_q == MODE_OFF) ? ST_IDLE : ST_RUN;
                    src_d      = pend_src_q;
                    mode_d     = pend_mode_q;
                    change_d   = 1'b1;
                    run_cnt_d  = '0;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign src_sel   = src_q;
    assign hvac_mode = mode_q;
    assign pump_en   = (mode_q != MODE_OFF);
    assign change    = change_q;

endmodule

// File: tb/tb_hvac_source_controller.sv
// Self-checking bench for hvac_source_controller: directed scenarios plus
// randomized samples checked cycle by cycle against a transaction-level model.
module tb_hvac_source_controller;

    localparam int DEAD = 16;
    localparam int MINR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] solar_level, solar_th;
    logic signed [7:0] room_temp, ambient_temp;
    logic signed [7:0] sc_th, sh_th, ac_th, ah_th, gc_th, gh_th;
    logic [1:0]  src_sel, hvac_mode;
    logic        pump_en, change;

    hvac_source_controller #(.DEAD_CYCLES(DEAD), .MIN_RUN_SAMPLES(MINR)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sample_valid           (sample_valid),
        .solar_level            (solar_level),
        .room_temp              (room_temp),
        .ambient_temp           (ambient_temp),
        .solar_th               (solar_th),
        .solar_cooldown_th      (sc_th),
        .solar_heatup_th        (sh_th),
        .ambient_cooldown_th    (ac_th),
        .ambient_heatup_th      (ah_th),
        .geothermal_cooldown_th (gc_th),
        .geothermal_heatup_th   (gh_th),
        .src_sel                (src_sel),
        .hvac_mode              (hvac_mode),
        .pump_en                (pump_en),
        .change                 (change)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // thresholds the bench intends the DUT to see for the next sample
    int t_st, t_sc, t_sh, t_ac, t_ah, t_gc, t_gh;
    // model: current outputs and accepted non-switching evaluations in RUN
    int m_src, m_mode, m_run;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int obs_now();
        return int'({src_sel, hvac_mode, pump_en, change});
    endfunction

    function automatic int exp_pack(input int s, input int m, input int ch);
        return (s << 4) | (m << 2) | ((m != 0) ? 2 : 0) | ch;
    endfunction

    // Spec rules: solar (if bright enough), ambient (if outside air helps),
    // geothermal; cooling before heating for each. s/m: source and mode codes.
    function automatic void ref_req(input int room, input int amb, input int sl,
                                    output int s, output int m);
        s = 0; m = 0;
        if      (sl >= t_st && room > t_sc)             begin s = 1; m = 2; end
        else if (sl >= t_st && room < t_sh)             begin s = 1; m = 1; end
        else if (amb < room && room > t_ac)             begin s = 2; m = 2; end
        else if (amb > room && room < t_ah)             begin s = 2; m = 1; end
        else if (room > t_gc)                           begin s = 3; m = 2; end
        else if (room < t_gh)                           begin s = 3; m = 1; end
    endfunction

    task automatic default_th();
        t_st = 2550;
        t_sc = 35; t_sh = 16; t_ac = 35; t_ah = 16; t_gc = 35; t_gh = 16;
    endtask

    task automatic drive(input int room, input int amb, input int sl);
        room_temp    = 8'(room);
        ambient_temp = 8'(amb);
        solar_level  = 16'(sl);
        solar_th     = 16'(t_st);
        sc_th = 8'(t_sc); sh_th = 8'(t_sh);
        ac_th = 8'(t_ac); ah_th = 8'(t_ah);
        gc_th = 8'(t_gc); gh_th = 8'(t_gh);
    endtask

    task automatic scramble();
        room_temp    = 8'($urandom);
        ambient_temp = 8'($urandom);
        solar_level  = 16'($urandom);
        solar_th     = 16'($urandom);
        sc_th = 8'($urandom); sh_th = 8'($urandom);
        ac_th = 8'($urandom); ah_th = 8'($urandom);
        gc_th = 8'($urandom); gh_th = 8'($urandom);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        chk(tag, obs_now(), 0);
        rst = 1'b0;
        m_src = 0; m_mode = 0; m_run = 0;
    endtask

    // One sample, then every cycle through the dead time and two cycles past
    // the switch point is compared. Inputs are scrambled after capture.
    task automatic send(input string tag, input int room, input int amb,
                        input int sl, input bit poke);
        int rs, rm, old_v, new_v, e, poke_k;
        bit sw;
        drive(room, amb, sl);
        sample_valid = 1'b1;
        ref_req(room, amb, sl, rs, rm);
        old_v = exp_pack(m_src, m_mode, 0);
        sw = 1'b0;
        if (rs == m_src && rm == m_mode) begin
            if (m_mode != 0 && m_run < MINR) m_run++;
        end else if (m_mode == 0 || m_run >= MINR) begin
            sw = 1'b1;
            m_src = rs; m_mode = rm; m_run = 0;
        end else begin
            m_run++;
        end
        new_v  = exp_pack(m_src, m_mode, 0);
        poke_k = poke ? int'($urandom_range(2, DEAD + 1)) : 0;
        tick();
        sample_valid = 1'b0;
        scramble();
        for (int k = 1; k <= DEAD + 3; k++) begin
            if (!sw || k == 1)      e = old_v;
            else if (k <= DEAD + 1) e = 0;
            else if (k == DEAD + 2) e = new_v | 1;
            else                    e = new_v;
            chk($sformatf("%s@c%0d", tag, k), obs_now(), e);
            sample_valid = sw && (k == poke_k);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        default_th();
        drive(0, 0, 0);
        m_src = 0; m_mode = 0; m_run = 0;
        tick(); tick(); tick();
        chk("reset_state", obs_now(), 0);
        rst = 1'b0;
        tick();

        send("solar_cool", 40, 30, 3000, 1'b0);
        for (int i = 0; i < 5; i++) send($sformatf("dwell%0d", i), 34, 30, 3000, 1'b0);
        send("idle_same", 20, 30, 3000, 1'b0);

        // reset during the fifth dead cycle must abort the pending switch
        drive(40, 30, 3000);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("rst_dead_pre", obs_now(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_src = 0; m_mode = 0; m_run = 0;
        for (int k = 0; k < DEAD + 4; k++) begin
            chk($sformatf("rst_dead_off@%0d", k), obs_now(), 0);
            tick();
        end
        send("after_rst", 40, 30, 3000, 1'b1);

        do_reset("rst_a");
        send("amb_heat", 10, 20, 1000, 1'b1);
        do_reset("rst_b");
        send("geo_heat", 10, 5, 1000, 1'b0);
        do_reset("rst_c");
        send("signed_geo", -5, -10, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                t_st = int'($urandom_range(0, 4000));
                t_sc = int'($urandom_range(0, 60)) - 20;
                t_sh = int'($urandom_range(0, 60)) - 20;
                t_ac = int'($urandom_range(0, 60)) - 20;
                t_ah = int'($urandom_range(0, 60)) - 20;
                t_gc = int'($urandom_range(0, 60)) - 20;
                t_gh = int'($urandom_range(0, 60)) - 20;
            end else begin
                default_th();
            end
            send($sformatf("rnd%0d", i),
                 int'($urandom_range(0, 100)) - 40,
                 int'($urandom_range(0, 100)) - 40,
                 int'($urandom_range(0, 5000)),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
